// File: rtl/cpu_mem_responder_if.sv
// Bus and UART-side signal bundle for cpu_mem_responder.
// master = CPU/UART side, slave = the responder.
interface cpu_mem_responder_if;
   logic [31:0] bus_a;
   logic        bus_wr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        halt;
   logic        tx_drop;

   modport master (
      output bus_a, bus_wr, bus_wdata, tx_ready, rx_data, rx_valid,
      input  bus_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, halt, tx_drop
   );

   modport slave (
      input  bus_a, bus_wr, bus_wdata, tx_ready, rx_data, rx_valid,
      output bus_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, halt, tx_drop
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// CPU memory-bus responder: on-chip RAM, UART TX/RX FIFOs, cycle counter snapshot.
// Optional RX path built only when CPU_MEM_RESPONDER_RX_EN is defined.
module cpu_mem_responder #(
   parameter int RAM_AW      = 17,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input logic                clk_in,
   input logic                rst_in,
   cpu_mem_responder_if.slave bus
);
   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_PW + 1;
   localparam logic [TX_CW-1:0] TX_DEPTH_C  = TX_CW'(TX_DEPTH);
   localparam logic [TX_CW-1:0] TX_FULL_LVL = TX_CW'(TX_DEPTH - FULL_MARGIN);

   // Handshakes (tx_*, rx_*) are valid/ready: a byte moves on every rising edge
   // where both are high; valid never depends on ready in the same cycle.

   logic is_io, io_tx, io_cnt, io_halt;
   assign is_io   = (bus.bus_a[17:16] == 2'b11);
   assign io_tx   = is_io && (bus.bus_a[15:0] == 16'h0000);
   assign io_cnt  = is_io && (bus.bus_a[15:2] == 14'h0001);
   assign io_halt = is_io && (bus.bus_a[15:0] == 16'h0004);

   logic halt_q, tx_drop_q, io_full_q;
   logic ram_wr, rx_rd_req;
   assign ram_wr    = bus.bus_wr && !is_io && !halt_q;
   assign rx_rd_req = !bus.bus_wr && io_tx;

   // RAM: contents not reset, synchronous read
   logic [7:0] ram [2**RAM_AW];
   logic [7:0] ram_q;
   always_ff @(posedge clk_in) begin
      if (ram_wr) ram[bus.bus_a[RAM_AW-1:0]] <= bus.bus_wdata;
      ram_q <= ram[bus.bus_a[RAM_AW-1:0]];
   end

   // TX FIFO
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0] tx_count, tx_count_next;
   logic             tx_push, tx_pop, tx_full, tx_accept;
   logic [7:0]       tx_push_data;

   assign tx_push      = bus.bus_wr && !halt_q &&
                         ((io_tx && (bus.bus_wdata != 8'h00)) || io_halt);
   assign tx_push_data = io_halt ? 8'h00 : bus.bus_wdata;
   assign bus.tx_valid = (tx_count != '0);
   assign bus.tx_data  = bus.tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
   assign tx_pop       = bus.tx_valid && bus.tx_ready;
   assign tx_full      = (tx_count == TX_DEPTH_C);
   // A same-cycle pop frees a slot before the push is judged.
   assign tx_accept    = tx_push && (!tx_full || tx_pop);

   always_comb begin
      tx_count_next = tx_count;
      case ({tx_accept, tx_pop})
         2'b10:   tx_count_next = tx_count + TX_CW'(1);
         2'b01:   tx_count_next = tx_count - TX_CW'(1);
         default: tx_count_next = tx_count;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (tx_accept) tx_mem[tx_wr_ptr] <= tx_push_data;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         io_full_q <= 1'b0;
         tx_drop_q <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         if (tx_accept) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
         if (tx_pop)    tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
         tx_count  <= tx_count_next;
         io_full_q <= (tx_count_next >= TX_FULL_LVL);
         if (tx_push && !tx_accept) tx_drop_q <= 1'b1;
         if (bus.bus_wr && io_halt)  halt_q    <= 1'b1;
      end
   end

   assign bus.io_buffer_full = io_full_q;
   assign bus.tx_drop        = tx_drop_q;
   assign bus.halt           = halt_q;

   // RX FIFO
   logic [7:0] rx_head;
`ifdef CPU_MEM_RESPONDER_RX_EN
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_PW + 1;
   localparam logic [RX_CW-1:0] RX_DEPTH_C = RX_CW'(RX_DEPTH);

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0] rx_count;
   logic             rx_empty, rx_full, rx_push, rx_pop;

   assign rx_empty     = (rx_count == '0);
   assign rx_full      = (rx_count == RX_DEPTH_C);
   assign bus.rx_ready = !rx_full;
   assign rx_push      = bus.rx_valid && !rx_full;
   assign rx_pop       = rx_rd_req && !rx_empty;
   assign rx_head      = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

   always_ff @(posedge clk_in) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + RX_CW'(1);
            2'b01:   rx_count <= rx_count - RX_CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end
`else
   logic unused_rx;
   assign bus.rx_ready = 1'b0;
   assign rx_head      = 8'h00;
   assign unused_rx    = ^{bus.rx_data, bus.rx_valid, rx_rd_req};
`endif

   // Cycle counter and the snapshot that keeps multi-byte reads coherent
   logic [31:0] cycle_cnt, snap;
   logic [7:0]  io_rdata_d, io_rdata_q;
   logic        rd_ram_q;

   always_comb begin
      io_rdata_d = 8'h00;
      if (rx_rd_req) begin
         io_rdata_d = rx_head;
      end else if (!bus.bus_wr && io_cnt) begin
         case (bus.bus_a[1:0])
            2'd0:    io_rdata_d = cycle_cnt[7:0];
            2'd1:    io_rdata_d = snap[15:8];
            2'd2:    io_rdata_d = snap[23:16];
            default: io_rdata_d = snap[31:24];
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cycle_cnt  <= '0;
         snap       <= '0;
         io_rdata_q <= 8'h00;
         rd_ram_q   <= 1'b0;
      end else begin
         cycle_cnt  <= cycle_cnt + 32'd1;
         if (!bus.bus_wr && io_cnt && (bus.bus_a[1:0] == 2'd0)) snap <= cycle_cnt;
         io_rdata_q <= io_rdata_d;
         rd_ram_q   <= !bus.bus_wr && !is_io;
      end
   end

   assign bus.bus_rdata = rd_ram_q ? ram_q : io_rdata_q;

   logic unused_bits;
   assign unused_bits = ^bus.bus_a[31:18];
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (RAM, TX, RX, counter, halt, reset).
module tb_cpu_mem_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

`ifdef CPU_MEM_RESPONDER_RX_EN
  localparam logic RX_RDY_RST = 1'b1;
`else
  localparam logic RX_RDY_RST = 1'b0;
`endif

  cpu_mem_responder_if bus_if ();

  cpu_mem_responder #(
    .RAM_AW(17), .TX_DEPTH(16), .RX_DEPTH(8), .FULL_MARGIN(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus_if.slave)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1) got_q.push_back(bus_if.tx_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic bus_cycle(input logic [31:0] a, input logic wr, input logic [7:0] wd);
    @(negedge clk_in);
    bus_if.bus_a = a;
    bus_if.bus_wr = wr;
    bus_if.bus_wdata = wd;
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(32'h0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    bus_if.bus_a = 32'h0;
    bus_if.bus_wr = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    #2 rst_in = 1'b1;
    #1;
    vec_cnt++; if (bus_if.bus_rdata !== 8'h00) begin err_cnt++; $display("FAIL rst_rdata: got %h exp 00", bus_if.bus_rdata); end
    vec_cnt++; if (bus_if.tx_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_tx_valid: got %b exp 0", bus_if.tx_valid); end
    vec_cnt++; if (bus_if.tx_data !== 8'h00) begin err_cnt++; $display("FAIL rst_tx_data: got %h exp 00", bus_if.tx_data); end
    vec_cnt++; if (bus_if.rx_ready !== RX_RDY_RST) begin err_cnt++; $display("FAIL rst_rx_ready: got %b exp %b", bus_if.rx_ready, RX_RDY_RST); end
    vec_cnt++; if (bus_if.io_buffer_full !== 1'b0) begin err_cnt++; $display("FAIL rst_io_full: got %b exp 0", bus_if.io_buffer_full); end
    vec_cnt++; if (bus_if.halt !== 1'b0) begin err_cnt++; $display("FAIL rst_halt: got %b exp 0", bus_if.halt); end
    vec_cnt++; if (bus_if.tx_drop !== 1'b0) begin err_cnt++; $display("FAIL rst_tx_drop: got %b exp 0", bus_if.tx_drop); end
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    bus_cycle(32'h0000_0010, 1'b1, 8'hA5);
    bus_cycle(32'h0000_0011, 1'b1, 8'h5A);
    bus_cycle(32'h0000_0010, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'hA5) begin err_cnt++; $display("FAIL ram_rd_10: got %h exp a5", bus_if.bus_rdata); end
    bus_cycle(32'h0002_0010, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'hA5) begin err_cnt++; $display("FAIL ram_alias: got %h exp a5", bus_if.bus_rdata); end
    bus_cycle(32'h0000_0011, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h5A) begin err_cnt++; $display("FAIL ram_rd_11: got %h exp 5a", bus_if.bus_rdata); end
    bus_cycle(32'h0003_0100, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h00) begin err_cnt++; $display("FAIL io_other_rd: got %h exp 00", bus_if.bus_rdata); end
  endtask

  task automatic test_tx_basic();
    got_q.delete();
    bus_if.tx_ready = 1'b1;
    bus_cycle(32'h0003_0000, 1'b1, 8'h48);
    vec_cnt++; if (bus_if.tx_valid !== 1'b1) begin err_cnt++; $display("FAIL tx_valid_rise: got %b exp 1", bus_if.tx_valid); end
    vec_cnt++; if (bus_if.tx_data !== 8'h48) begin err_cnt++; $display("FAIL tx_head: got %h exp 48", bus_if.tx_data); end
    bus_cycle(32'h0003_0000, 1'b1, 8'h00);
    vec_cnt++; if (bus_if.tx_valid !== 1'b0) begin err_cnt++; $display("FAIL tx_zero_ignored: got %b exp 0", bus_if.tx_valid); end
    bus_idle(3);
    vec_cnt++; if (got_q.size() != 1) begin err_cnt++; $display("FAIL tx_basic_count: got %0d exp 1", got_q.size()); end
    else begin
      vec_cnt++; if (got_q[0] !== 8'h48) begin err_cnt++; $display("FAIL tx_basic_byte: got %h exp 48", got_q[0]); end
    end
  endtask

  task automatic test_tx_fill();
    int model_cnt;
    do_reset();
    bus_if.tx_ready = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      bus_cycle(32'h0003_0000, 1'b1, 8'(i));
      if (model_cnt < 16) begin exp_q.push_back(8'(i)); model_cnt++; end
      if (i == 13) begin
        vec_cnt++; if (bus_if.io_buffer_full !== 1'b0) begin err_cnt++; $display("FAIL io_full_13: got %b exp 0", bus_if.io_buffer_full); end
      end
      if (i == 14) begin
        vec_cnt++; if (bus_if.io_buffer_full !== 1'b1) begin err_cnt++; $display("FAIL io_full_14: got %b exp 1", bus_if.io_buffer_full); end
        vec_cnt++; if (bus_if.tx_data !== 8'h01) begin err_cnt++; $display("FAIL tx_head_hold: got %h exp 01", bus_if.tx_data); end
      end
      if (i == 16) begin
        vec_cnt++; if (bus_if.tx_drop !== 1'b0) begin err_cnt++; $display("FAIL tx_drop_16: got %b exp 0", bus_if.tx_drop); end
      end
      if (i == 17) begin
        vec_cnt++; if (bus_if.tx_drop !== 1'b1) begin err_cnt++; $display("FAIL tx_drop_17: got %b exp 1", bus_if.tx_drop); end
      end
    end
    bus_if.tx_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bus_idle(1);
      if (bus_if.tx_valid === 1'b0) break;
    end
    vec_cnt++; if (bus_if.tx_valid !== 1'b0) begin err_cnt++; $display("FAIL tx_drain_timeout: tx_valid %b exp 0", bus_if.tx_valid); end
    vec_cnt++; if (bus_if.io_buffer_full !== 1'b0) begin err_cnt++; $display("FAIL io_full_drained: got %b exp 0", bus_if.io_buffer_full); end
    vec_cnt++; if (got_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL tx_fill_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vec_cnt++; if (got_q[k] !== exp_q[k]) begin err_cnt++; $display("FAIL tx_fill_byte%0d: got %h exp %h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_rx();
`ifdef CPU_MEM_RESPONDER_RX_EN
    @(negedge clk_in);
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h31;
    @(negedge clk_in);
    bus_if.rx_data = 8'h32;
    @(negedge clk_in);
    bus_if.rx_valid = 1'b0;
    vec_cnt++; if (bus_if.rx_ready !== 1'b1) begin err_cnt++; $display("FAIL rx_ready_2: got %b exp 1", bus_if.rx_ready); end
    bus_cycle(32'h0003_0000, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h31) begin err_cnt++; $display("FAIL rx_rd0: got %h exp 31", bus_if.bus_rdata); end
    bus_cycle(32'h0003_0000, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h32) begin err_cnt++; $display("FAIL rx_rd1: got %h exp 32", bus_if.bus_rdata); end
    bus_cycle(32'h0003_0000, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h00) begin err_cnt++; $display("FAIL rx_rd_empty: got %h exp 00", bus_if.bus_rdata); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_in);
      bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'(8'h40 + i);
    end
    @(negedge clk_in);
    bus_if.rx_valid = 1'b0;
    vec_cnt++; if (bus_if.rx_ready !== 1'b0) begin err_cnt++; $display("FAIL rx_ready_full: got %b exp 0", bus_if.rx_ready); end
    for (int i = 0; i < 9; i++) begin
      bus_cycle(32'h0003_0000, 1'b0, 8'h00);
      vec_cnt++;
      if (bus_if.bus_rdata !== ((i < 8) ? 8'(8'h40 + i) : 8'h00)) begin
        err_cnt++; $display("FAIL rx_fill_rd%0d: got %h exp %h", i, bus_if.bus_rdata, (i < 8) ? 8'(8'h40 + i) : 8'h00);
      end
    end
`else
    @(negedge clk_in);
    bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h55;
    bus_cycle(32'h0003_0000, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.rx_ready !== 1'b0) begin err_cnt++; $display("FAIL rx_ready_off: got %b exp 0", bus_if.rx_ready); end
    bus_cycle(32'h0003_0000, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'h00) begin err_cnt++; $display("FAIL rx_rd_off: got %h exp 00", bus_if.bus_rdata); end
    bus_if.rx_valid = 1'b0;
`endif
  endtask

  task automatic test_counter();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hFF; exp_b[1] = 8'h01; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    do_reset();
    repeat (32'h1FF) @(posedge clk_in);
    for (int i = 0; i < 4; i++) begin
      bus_cycle(32'h0003_0004 + 32'(i), 1'b0, 8'h00);
      vec_cnt++; if (bus_if.bus_rdata !== exp_b[i]) begin err_cnt++; $display("FAIL cnt_byte%0d: got %h exp %h", i, bus_if.bus_rdata, exp_b[i]); end
    end
  endtask

  task automatic test_halt();
    got_q.delete();
    bus_if.tx_ready = 1'b1;
    bus_cycle(32'h0003_0004, 1'b1, 8'h00);
    vec_cnt++; if (bus_if.halt !== 1'b1) begin err_cnt++; $display("FAIL halt_set: got %b exp 1", bus_if.halt); end
    vec_cnt++; if (bus_if.tx_valid !== 1'b1) begin err_cnt++; $display("FAIL halt_tx_valid: got %b exp 1", bus_if.tx_valid); end
    bus_cycle(32'h0000_0010, 1'b1, 8'h77);
    bus_cycle(32'h0003_0000, 1'b1, 8'h41);
    bus_cycle(32'h0000_0010, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.bus_rdata !== 8'hA5) begin err_cnt++; $display("FAIL halt_ram_kept: got %h exp a5", bus_if.bus_rdata); end
    bus_idle(3);
    vec_cnt++; if (got_q.size() != 1) begin err_cnt++; $display("FAIL halt_tx_count: got %0d exp 1", got_q.size()); end
    else begin
      vec_cnt++; if (got_q[0] !== 8'h00) begin err_cnt++; $display("FAIL halt_tx_byte: got %h exp 00", got_q[0]); end
    end
    vec_cnt++; if (bus_if.halt !== 1'b1) begin err_cnt++; $display("FAIL halt_sticky: got %b exp 1", bus_if.halt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) bus_cycle(32'h0003_0000, 1'b1, 8'(8'h60 + i));
    bus_cycle(32'h0003_0004, 1'b1, 8'h00);
    bus_cycle(32'h0000_0010, 1'b0, 8'h00);
    vec_cnt++; if (bus_if.io_buffer_full !== 1'b1) begin err_cnt++; $display("FAIL pre_rst_full: got %b exp 1", bus_if.io_buffer_full); end
    vec_cnt++; if (bus_if.bus_rdata !== 8'hA5) begin err_cnt++; $display("FAIL pre_rst_rdata: got %h exp a5", bus_if.bus_rdata); end
    #2 rst_in = 1'b1;
    #1;
    vec_cnt++; if (bus_if.tx_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_tx_valid: got %b exp 0", bus_if.tx_valid); end
    vec_cnt++; if (bus_if.halt !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_halt: got %b exp 0", bus_if.halt); end
    vec_cnt++; if (bus_if.io_buffer_full !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_full: got %b exp 0", bus_if.io_buffer_full); end
    vec_cnt++; if (bus_if.bus_rdata !== 8'h00) begin err_cnt++; $display("FAIL mid_rst_rdata: got %h exp 00", bus_if.bus_rdata); end
    @(negedge clk_in);
    rst_in = 1'b0;
    bus_idle(2);
    vec_cnt++; if (bus_if.tx_valid !== 1'b0) begin err_cnt++; $display("FAIL post_rst_tx_valid: got %b exp 0", bus_if.tx_valid); end
  endtask

  initial begin
    bus_if.bus_a = 32'h0;
    bus_if.bus_wr = 1'b0;
    bus_if.bus_wdata = 8'h00;
    bus_if.tx_ready = 1'b0;
    bus_if.rx_data = 8'h00;
    bus_if.rx_valid = 1'b0;
    test_reset();
    test_ram();
    test_tx_basic();
    test_tx_fill();
    test_rx();
    test_counter();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
